// File: rtl/viterbi_decode_if.sv
// Symbol/decision bundle for viterbi_decode.
//   master : drives in_valid, Y2N, Y1N, Y0N; samples X2N_hat, X1N_hat, out_valid
//   slave  : the decoder side (consumes the received symbol, returns decisions)
interface viterbi_decode_if;
    logic in_valid;
    logic Y2N;
    logic Y1N;
    logic Y0N;
    logic X2N_hat;
    logic X1N_hat;
    logic out_valid;

    modport master (
        output in_valid, Y2N, Y1N, Y0N,
        input  X2N_hat, X1N_hat, out_valid
    );

    modport slave (
        input  in_valid, Y2N, Y1N, Y0N,
        output X2N_hat, X1N_hat, out_valid
    );
endinterface

// File: rtl/viterbi_decode.sv
// Hard-decision Viterbi decoder for the rate-2/3 trellis code.
// X1N is decoded over a 4-state trellis with register-exchange survivors;
// X2N is uncoded and delayed so it lines up with the decoded X1N.
//   clk : single clock, rising edge
//   res : asynchronous active-low reset
//   bus : viterbi_decode_if.slave
//         in_valid/Y2N/Y1N/Y0N in, X2N_hat/X1N_hat/out_valid out (registered)
// Parameters:
//   TB_DEPTH : survivor length D and decode latency in accepted symbols (4..32)
//   PM_W     : path-metric width (>= 4)
module viterbi_decode #(
    parameter int unsigned TB_DEPTH = 16,
    parameter int unsigned PM_W     = 5
) (
    input logic             clk,
    input logic             res,
    viterbi_decode_if.slave bus
);
    localparam int unsigned CW = $clog2(TB_DEPTH);
    localparam int unsigned EW = PM_W + 1;
    localparam logic [PM_W-1:0] PM_MAX  = '1;
    localparam logic [PM_W-1:0] PM_INIT = PM_W'(4);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TB_DEPTH - 1);

    // The oldest survivor / delay-line bit goes straight into the output
    // register on the accepting edge, so only D-1 bits need to be stored.
    logic [PM_W-1:0]     pm_q   [4];
    logic [TB_DEPTH-2:0] surv_q [4];
    logic [TB_DEPTH-2:0] dly_q;
    logic [CW-1:0]       cnt_q;
    logic                x1_hat_q;
    logic                x2_hat_q;
    logic                out_valid_q;

    logic [EW-1:0]       acs    [4];
    logic [PM_W-1:0]     pm_n   [4];
    logic [TB_DEPTH-1:0] surv_n [4];
    logic [TB_DEPTH-1:0] dly_n;
    logic [EW-1:0]       min_m;
    logic [1:0]          best;

    logic [1:0]    idx;
    logic [1:0]    p0;
    logic [1:0]    p1;
    logic          y0_err;
    logic [1:0]    bm0;
    logic [1:0]    bm1;
    logic [EW-1:0] c0;
    logic [EW-1:0] c1;
    logic [EW-1:0] diff;

    // Add-compare-select, normalisation and best-state pick.
    // State index n = {x,a}; predecessors are {a,0} and {a,1}.
    always_comb begin
        idx    = '0;
        p0     = '0;
        p1     = '0;
        y0_err = 1'b0;
        bm0    = '0;
        bm1    = '0;
        c0     = '0;
        c1     = '0;
        diff   = '0;
        min_m  = '1;
        best   = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            idx    = 2'(n);
            p0     = {idx[0], 1'b0};
            p1     = {idx[0], 1'b1};
            y0_err = (bus.Y0N != idx[0]);
            // From p0 the expected Y1 is x, from p1 it is ~x.
            bm0 = {1'b0, y0_err} + {1'b0, (bus.Y1N != idx[1])};
            bm1 = {1'b0, y0_err} + {1'b0, (bus.Y1N == idx[1])};
            c0  = {1'b0, pm_q[p0]} + EW'(bm0);
            c1  = {1'b0, pm_q[p1]} + EW'(bm1);
            if (c1 < c0) begin
                acs[n]    = c1;
                surv_n[n] = {surv_q[p1], idx[1]};
            end else begin
                acs[n]    = c0;
                surv_n[n] = {surv_q[p0], idx[1]};
            end
        end
        // Strict compare keeps the lowest index on ties.
        for (int unsigned n = 0; n < 4; n++) begin
            if (acs[n] < min_m) begin
                min_m = acs[n];
                best  = 2'(n);
            end
        end
        for (int unsigned n = 0; n < 4; n++) begin
            diff    = acs[n] - min_m;
            pm_n[n] = (diff > EW'(PM_MAX)) ? PM_MAX : diff[PM_W-1:0];
        end
    end

    assign dly_n = {dly_q, bus.Y2N};

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pm_q[0] <= '0;
            pm_q[1] <= PM_INIT;
            pm_q[2] <= PM_INIT;
            pm_q[3] <= PM_INIT;
            for (int unsigned i = 0; i < 4; i++) begin
                surv_q[i] <= '0;
            end
            dly_q       <= '0;
            cnt_q       <= '0;
            x1_hat_q    <= 1'b0;
            x2_hat_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    pm_q[i]   <= pm_n[i];
                    surv_q[i] <= surv_n[i][TB_DEPTH-2:0];
                end
                dly_q <= dly_n[TB_DEPTH-2:0];
                if (cnt_q != CNT_LAST) begin
                    cnt_q <= cnt_q + CW'(1);
                end
                x1_hat_q    <= surv_n[best][TB_DEPTH-1];
                x2_hat_q    <= dly_n[TB_DEPTH-1];
                out_valid_q <= (cnt_q == CNT_LAST);
            end
        end
    end

    assign bus.X1N_hat   = x1_hat_q;
    assign bus.X2N_hat   = x2_hat_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: doc/viterbi_decode.md
# viterbi_decode

Hard-decision Viterbi decoder for the rate-2/3 trellis encoder: it consumes one received (Y2N, Y1N, Y0N) symbol per valid cycle and recovers (X2N, X1N). It sits directly downstream of the encoder, after the channel model. X1N is decoded over the 4-state trellis with register-exchange survivors. X2N is uncoded and is passed through a delay line so it stays aligned with the decoded X1N.

## Interface
- TB_DEPTH, 16: survivor (register-exchange) length D in bits; also decode latency in accepted symbols; legal 4..32
- PM_W, 5: path-metric width in bits; legal ≥4
- clk  in  1  single clock; all state updates on rising edge
- res  in  1  reset, asynchronous, active-low
- in_valid  in  1  received symbol on Y2N/Y1N/Y0N is accepted this cycle
- Y2N  in  1  received uncoded bit
- Y1N  in  1  received coded bit (X1N ^ X1N delayed 2)
- Y0N  in  1  received coded bit (X1N delayed 1)
- X2N_hat  out  1  decoded X2N, registered
- X1N_hat  out  1  decoded X1N, registered
- out_valid  out  1  X2N_hat/X1N_hat valid this cycle, registered

## Operation
- Trellis state s = {a,b}: a is the previous X1N and b is the X1N before that; index = 2a+b.
- For input x from state {a,b}, the next state is {x,a}. The expected outputs are Y0 = a and Y1 = x^b.
- Branch metric (0..2) = (Y0N != a) + (Y1N != x^b). Y2N does not contribute.
- ACS for next state n = {x,a}: there are two predecessors, p0 = {a,0} (expected Y1 = x) and p1 = {a,1} (expected Y1 = ~x).
  - Candidate = PM[p] + BM.
  - Select the smaller candidate. On a tie, select p0.
- Normalization: after ACS, subtract the minimum of the four new metrics from all four, so the minimum is always 0. Any value exceeding 2^PM_W−1 saturates there.
- Survivors: each state holds D bits. The new survivor of n is the selected predecessor's survivor shifted one place, with x appended as the newest bit (bit 0).
- Best state = the state with the smallest new metric; ties go to the lowest index.
  - X1N_hat ← bit D−1 (oldest) of the best state's new survivor.
- X2N delay line: D-stage shift of Y2N advancing on in_valid. X2N_hat ← the entry that is D−1 accepted symbols old, i.e. aligned with X1N_hat.
- Symbol counter: saturates at D−1.
- When in_valid = 0, metrics, survivors, delay line, counter and X*_hat all hold.
- Reset (res low, any time including mid-stream) clears immediately:
  - PM = {0,4,4,4} for states 0..3 (the encoder starts in state 00), saturated to PM_W
  - survivors, delay line and counter = 0
  - X1N_hat = X2N_hat = out_valid = 0
- After res deasserts, the next accepted symbol is treated as symbol 0 of a fresh stream.

## Timing
- Single-cycle ACS. All next-state values and best-state selection are combinational from current registers plus the inputs.
- Every register updates on the same edge that accepts the symbol.
- Symbol k is accepted on edge k (counting accepted edges only, from 0).
- out_valid = 1 for exactly the cycle after each accepting edge k with k ≥ D−1. It is 0 after non-accepting edges.
- The output after edge k decodes symbol k−D+1, so the latency is D−1 accepted symbols plus one register stage. Idle cycles add latency 1:1.
- No backpressure: the block accepts a symbol every cycle that in_valid = 1.
- in_valid gaps never shift alignment between X1N_hat and X2N_hat.

## Test plan
- Reset values: drive res low mid-run → out_valid = X1N_hat = X2N_hat = 0 immediately (asynchronously). After release, the first out_valid appears after the D-th accepted symbol.
- Error-free all-ones: X1N = 1 continuously, received (Y1N,Y0N) = (1,0),(1,1),(0,1),(0,1)…, D = 16 → from the cycle after accepted edge 15, X1N_hat = 1 on every valid output. X1N_hat = 1 for symbol 0.
- Random error-free: 1000 symbols from a reference encoder model with random X2N/X1N → X1N_hat and X2N_hat equal the inputs delayed D−1 accepted symbols, with zero mismatches.
- Single error: same stream, flip Y1N on symbol 40 only → X1N_hat output is still error-free. Flip Y2N on symbol 50 → exactly one X2N_hat error, for symbol 50.
- Valid gaps: random 0–3 idle cycles between symbols of the random stream → decoded sequence is identical to the gap-free run, and out_valid never asserts on idle-following cycles.
- Metric bound: 500 symbols of random bits on Y1N/Y0N (worst case) → the minimum PM is 0 every cycle, no PM exceeds 2^PM_W−1, and no X/Z appears on any output.
